ram_access_sequencer: RTL and testbench
=======================================

# ram_access_sequencer

Byte-serial data-memory sequencer sitting directly downstream of the single load/store manager. It consumes that block's 4-bit RAM control bus (R/W, sign extension, data size), performs the requested byte/halfword/word/doubleword access on an internal byte-wide RAM one byte per cycle, and returns formatted read data plus a one-cycle completion pulse to the control unit. Big-endian byte order throughout.

## Interface

- ADDR_W, 9 — RAM address width; depth = 2**ADDR_W bytes.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mfa  input  1  memory function activate; start strobe, sampled only in IDLE.
- ctrl  input  4  RAM control bus: [3] 1=read/0=write, [2] sign-extend, [1:0] size (00 byte, 01 halfword, 10 word, 11 doubleword).
- addr  input  32  byte address; only addr[ADDR_W-1:0] used.
- wdata  input  64  store data, right-justified by size.
- rdata  output  64  load result, valid from moc until the next accepted mfa.
- moc  output  1  memory operation complete; one-cycle pulse.
- busy  output  1  high from the cycle after mfa is accepted through the moc cycle.
- align_err  output  1  misaligned request flag, valid with moc (see Configuration).

## Operation

- States: IDLE, XFER, DONE.
- IDLE: on mfa=1, latch ctrl, addr[ADDR_W-1:0], wdata; load byte counter with N-1 (N = 1, 2, 4, 8 for size 00/01/10/11); clear rdata; go XFER.
- XFER: one byte per cycle at address base+i (i = 0..N-1, modulo 2**ADDR_W, wraps at top of RAM). Byte i is the (N-1-i)-th byte of the sized field (big-endian: lowest address = most significant).
  - Write: mem[base+i] <= wdata byte (N-1-i).
  - Read: combinational RAM read; byte shifted into assembly register from the LSB end.
  - After byte N-1, go DONE.
- DONE: moc=1 for exactly one cycle; rdata driven from the formatted result; return to IDLE.
- Read formatting: byte/halfword zero- or sign-extended (from bit 7/15) to 32 bits, rdata[63:32]=0; word in rdata[31:0], rdata[63:32]=0; doubleword fills rdata[63:0]. ctrl[2] ignored for word/doubleword. Writes leave rdata at 0.
- mfa in XFER or DONE is ignored (not queued); the latched request is unaffected by input changes after acceptance.
- RAM contents are not reset; only state, counter, and outputs.

## Timing

- Reset values: state IDLE, rdata=0, moc=0, busy=0, align_err=0, counter=0.
- Latency mfa accept -> moc: N+1 cycles (byte 2, halfword 3, word 5, doubleword 9).
- mfa re-asserted in the same cycle moc is high is ignored; earliest next acceptance is the cycle after moc (back-to-back spacing N+2).
- rst_n low mid-transfer: immediate return to IDLE, no moc; bytes already written remain written, remaining bytes not written.

## Configuration

- RAM_ALIGN_CHECK_EN defined: request with addr not aligned to its size (halfword addr[0]!=0; word addr[1:0]!=0; doubleword addr[2:0]!=0) skips XFER: IDLE -> DONE, no RAM write, rdata=0, align_err=1 with moc (latency 1). Aligned requests: align_err=0.
- Undefined: no check; misaligned accesses proceed byte-serially with wrap; align_err tied 0.

## Test plan

- Reset: hold rst_n=0 with mfa=1 -> rdata=0, moc=0, busy=0; release, no spurious moc.
- Byte store 0x80 at 0x010 (ctrl=0000), then signed byte load (ctrl=1100) -> moc 2 cycles after each mfa, rdata=0x00000000FFFFFF80; unsigned (ctrl=1000) -> 0x80.
- Word store 0x11223344 at 0x020 (ctrl=0010) -> mem[0x020..0x023]=11,22,33,44; halfword load at 0x022 signed -> 0x3344.
- Doubleword store 0x0123456789ABCDEF at 0x1FC with wrap (ADDR_W=9, macro off) -> bytes at 0x1FC..0x1FF,0x000..0x003; load returns same value, moc 9 cycles after mfa.
- Word load at 0x021: macro on -> moc after 1 cycle, align_err=1, rdata=0, RAM unchanged; macro off -> normal 5-cycle access, align_err=0.
- mfa pulsed during XFER -> ignored, exactly one moc; rst_n low after 2 bytes of a word store -> only first 2 bytes changed, no moc.

Source files
------------

// File: rtl/ram_access_sequencer_if.sv
// ram_access_sequencer_if: request/response bundle between the
// load/store manager (master) and the RAM sequencer (slave).
interface ram_access_sequencer_if;
    logic        mfa;
    logic [3:0]  ctrl;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        moc;
    logic        busy;
    logic        align_err;

    modport master (
        output mfa, ctrl, addr, wdata,
        input  rdata, moc, busy, align_err
    );

    modport slave (
        input  mfa, ctrl, addr, wdata,
        output rdata, moc, busy, align_err
    );
endinterface

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: byte-serial big-endian data RAM sequencer.
// Optional misalignment trap: define RAM_ALIGN_CHECK_EN.
module ram_access_sequencer #(
    parameter int ADDR_W = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_access_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [63:0]       asm_q, asm_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              align_q, align_d;

    logic [7:0]        mem [2**ADDR_W];
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        rd_byte;
    logic [63:0]       full;
    logic [63:0]       fmt;
    logic              we;
    logic              misalign;
    logic              unused_bits;

    function automatic logic [2:0] nm1_of(input logic [1:0] sz);
        logic [2:0] r;
        unique case (sz)
            2'b00: r = 3'd0;
            2'b01: r = 3'd1;
            2'b10: r = 3'd3;
            2'b11: r = 3'd7;
        endcase
        return r;
    endfunction

    // Byte i lives at base+i and is byte (N-1-i) of the field; cnt = N-1-i.
    assign ptr     = base_q + ADDR_W'(nm1_of(ctrl_q[1:0]) - cnt_q);
    assign rd_byte = mem[ptr];
    assign full    = {asm_q[55:0], rd_byte};

    assign unused_bits = ^{bus.addr[31:ADDR_W], asm_q[63:56]};

`ifdef RAM_ALIGN_CHECK_EN
    // Size-aligned check on the incoming request address.
    always_comb begin
        misalign = 1'b0;
        unique case (bus.ctrl[1:0])
            2'b00: misalign = 1'b0;
            2'b01: misalign = bus.addr[0];
            2'b10: misalign = |bus.addr[1:0];
            2'b11: misalign = |bus.addr[2:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Extend the assembled bytes according to size and sign flag.
    always_comb begin
        fmt = 64'd0;
        unique case (ctrl_q[1:0])
            2'b00: fmt = {32'd0, {24{ctrl_q[2] & full[7]}}, full[7:0]};
            2'b01: fmt = {32'd0, {16{ctrl_q[2] & full[15]}}, full[15:0]};
            2'b10: fmt = {32'd0, full[31:0]};
            2'b11: fmt = full;
        endcase
    end

    // Next-state and datapath updates for the transfer FSM.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        align_d = align_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.mfa) begin
                    ctrl_d  = bus.ctrl;
                    base_d  = bus.addr[ADDR_W-1:0];
                    wdata_d = bus.wdata;
                    cnt_d   = nm1_of(bus.ctrl[1:0]);
                    asm_d   = 64'd0;
                    rdata_d = 64'd0;
                    align_d = misalign;
                    state_d = misalign ? DONE : XFER;
                end
            end
            XFER: begin
                we    = ~ctrl_q[3];
                asm_d = full;
                if (cnt_q == 3'd0) begin
                    state_d = DONE;
                    if (ctrl_q[3]) rdata_d = fmt;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= 4'd0;
            base_q  <= '0;
            wdata_q <= 64'd0;
            cnt_q   <= 3'd0;
            asm_q   <= 64'd0;
            rdata_q <= 64'd0;
            align_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            align_q <= align_d;
        end
    end

    // Byte-wide RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[ptr] <= wdata_q[{cnt_q, 3'b000} +: 8];
    end

    assign bus.rdata     = rdata_q;
    assign bus.moc       = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.align_err = align_q;
endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer: directed + random checks against a
// byte-array reference of the RAM and request rules.
module tb_ram_access_sequencer;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_access_sequencer_if bif ();

    ram_access_sequencer #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef RAM_ALIGN_CHECK_EN
        return (a & ((32'd1 << sz) - 32'd1)) != 32'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ridx(input logic [31:0] a, input int i);
        return (int'(a[AW-1:0]) + i) % DEPTH;
    endfunction

    function automatic logic [63:0] ref_read(input logic [3:0] c,
                                              input logic [31:0] a);
        int n = 1 << c[1:0];
        logic [63:0] v = 64'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[ridx(a, i)]);
        if (c[1:0] == 2'b00)
            v = {32'd0, {24{c[2] & v[7]}}, v[7:0]};
        else if (c[1:0] == 2'b01)
            v = {32'd0, {16{c[2] & v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_write(input logic [1:0] sz, input logic [31:0] a,
                             input logic [63:0] wd);
        int n = 1 << sz;
        for (int i = 0; i < n; i++)
            ref_mem[ridx(a, i)] = wd[8*(n-1-i) +: 8];
    endtask

    task automatic do_op(input string tag, input logic [3:0] c,
                         input logic [31:0] a, input logic [63:0] wd,
                         input bit pulse, output logic [63:0] rd);
        int n = 1 << c[1:0];
        bit mis = misal(c[1:0], a);
        int exp_lat = mis ? 1 : n + 1;
        int lat = 0;
        int extra = 0;
        logic [63:0] exp_rd;
        exp_rd = (c[3] && !mis) ? ref_read(c, a) : 64'd0;
        if (!c[3] && !mis) ref_write(c[1:0], a, wd);
        @(negedge clk);
        bif.mfa = 1'b1; bif.ctrl = c; bif.addr = a; bif.wdata = wd;
        @(posedge clk); #1;
        bif.mfa = 1'b0;
        bif.ctrl = 4'($urandom);
        bif.addr = $urandom;
        bif.wdata = {$urandom, $urandom};
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, ".busy1"}, 64'(bif.busy), 64'd1);
            if (pulse && k == 2) bif.mfa = 1'b1;
            if (pulse && k == 3) bif.mfa = 1'b0;
            if (bif.moc) begin lat = k; break; end
        end
        bif.mfa = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".rdata"}, bif.rdata, exp_rd);
        check({tag, ".align"}, 64'(bif.align_err), 64'(mis));
        check({tag, ".busymoc"}, 64'(bif.busy), 64'd1);
        rd = bif.rdata;
        if (pulse) bif.mfa = 1'b1;
        @(negedge clk);
        bif.mfa = 1'b0;
        check({tag, ".mocpulse"}, 64'(bif.moc), 64'd0);
        if (pulse) begin
            check({tag, ".mfa_at_moc"}, 64'(bif.busy), 64'd0);
            for (int k = 0; k < n + 3; k++) begin
                @(negedge clk);
                if (bif.moc) extra++;
            end
            check({tag, ".single_moc"}, 64'(extra), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] w;
        int any_moc;
        bif.mfa = 1'b1; bif.ctrl = 4'b1011;
        bif.addr = 32'h10; bif.wdata = 64'd0;
        repeat (3) @(negedge clk);
        check("rst.rdata", bif.rdata, 64'd0);
        check("rst.moc", 64'(bif.moc), 64'd0);
        check("rst.busy", 64'(bif.busy), 64'd0);
        check("rst.align", 64'(bif.align_err), 64'd0);
        bif.mfa = 1'b0;
        rst_n = 1'b1;
        any_moc = 0;
        repeat (3) begin
            @(negedge clk);
            if (bif.moc || bif.busy) any_moc++;
        end
        check("rst.release", 64'(any_moc), 64'd0);

        for (int i = 0; i < DEPTH / 8; i++)
            do_op("fill", 4'b0011, 32'(i * 8), {$urandom, $urandom}, 1'b0, rd);

        do_op("sb80", 4'b0000, 32'h010, 64'h80, 1'b0, rd);
        do_op("lbs", 4'b1100, 32'h010, 64'd0, 1'b0, rd);
        check("lbs.const", rd, 64'h00000000FFFFFF80);
        do_op("lbu", 4'b1000, 32'h010, 64'd0, 1'b0, rd);
        check("lbu.const", rd, 64'h80);

        do_op("sw", 4'b0010, 32'h020, 64'h11223344, 1'b0, rd);
        for (int i = 0; i < 4; i++) begin
            do_op("lbw", 4'b1000, 32'(32'h20 + i), 64'd0, 1'b0, rd);
            w = 64'h11223344;
            check("sw.byte", rd, 64'(w[8*(3-i) +: 8]));
        end
        do_op("lhs", 4'b1101, 32'h022, 64'd0, 1'b0, rd);
        check("lhs.const", rd, 64'h3344);

        do_op("sdw", 4'b0011, 32'h1FC, 64'h0123456789ABCDEF, 1'b0, rd);
        do_op("ldw", 4'b1011, 32'h1FC, 64'd0, 1'b0, rd);
`ifndef RAM_ALIGN_CHECK_EN
        check("ldw.const", rd, 64'h0123456789ABCDEF);
        do_op("lb0", 4'b1000, 32'h000, 64'd0, 1'b0, rd);
        check("wrap.byte0", rd, 64'h89);
`endif
        do_op("lw21", 4'b1010, 32'h021, 64'd0, 1'b0, rd);
        do_op("sw21", 4'b0010, 32'h021, 64'hDEADBEEF, 1'b0, rd);
        do_op("lw20", 4'b1010, 32'h020, 64'd0, 1'b0, rd);

        do_op("pulse", 4'b1010, 32'h020, 64'd0, 1'b1, rd);

        w = 64'hA1B2C3D4;
        ref_mem[9'h040] = w[31:24];
        ref_mem[9'h041] = w[23:16];
        @(negedge clk);
        bif.mfa = 1'b1; bif.ctrl = 4'b0010;
        bif.addr = 32'h040; bif.wdata = w;
        @(posedge clk); #1;
        bif.mfa = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst.busy", 64'(bif.busy), 64'd0);
        check("mrst.rdata", bif.rdata, 64'd0);
        any_moc = 0;
        repeat (3) begin
            @(negedge clk);
            if (bif.moc) any_moc++;
        end
        check("mrst.nomoc", 64'(any_moc), 64'd0);
        rst_n = 1'b1;
        do_op("mrst.lw", 4'b1010, 32'h040, 64'd0, 1'b0, rd);

        for (int i = 0; i < 80; i++)
            do_op("rnd", 4'($urandom), 32'($urandom_range(0, DEPTH - 1)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0), rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
